gray_counter: RTL and testbench



---
 rtl/gray_counter.sv | 100 ++++++++++
 tb/tb_gray_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary+Gray counter with sync load, terminal count and wrap pulse; GRAY_COUNTER_SAT_EN selects saturation instead of wrap.
// Latency: 1 cycle from load/ena to bin/gray/wrap; tc is combinational from state and up_dn.
// Backpressure: none, one step per enabled cycle; gray comes straight from a flop for CDC use.
module gray_counter #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;

    logic             w_at_max;
    logic             w_at_min;
    logic             w_at_end;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;

    assign w_at_max = (r_bin == MAX_VAL);
    assign w_at_min = (r_bin == MIN_VAL);
    // The end of range in the direction of travel: also exactly the tc condition.
    assign w_at_end = up_dn ? w_at_max : w_at_min;

`ifdef GRAY_COUNTER_SAT_EN
    // Holding at the end of range keeps the zero-or-one-bit Gray step property.
    always_comb begin
        w_bin_step = r_bin;
        if (!w_at_end) begin
            w_bin_step = up_dn ? (r_bin + ONE_VAL) : (r_bin - ONE_VAL);
        end
    end
`else
    always_comb begin
        w_bin_step = up_dn ? (r_bin + ONE_VAL) : (r_bin - ONE_VAL);
    end
`endif

    always_comb begin
        w_bin_nxt = r_bin;
        if (load) begin
            w_bin_nxt = load_bin;
        end else if (ena) begin
            w_bin_nxt = w_bin_step;
        end
    end

    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= RST_BIN;
            r_gray <= RST_GRAY;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
        end
    end

`ifdef GRAY_COUNTER_SAT_EN
    assign wrap = 1'b0;
`else
    logic r_wrap;
    logic w_wrap_nxt;

    // A wrap is any enabled, non-load step taken from the end of range.
    assign w_wrap_nxt = ena & ~load & w_at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

    assign wrap = r_wrap;
`endif

    assign bin  = r_bin;
    assign gray = r_gray;
    assign tc   = w_at_end;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed 4-bit scenarios plus a randomised 8-bit run against an integer reference model.
module tb_gray_counter;

`ifdef GRAY_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, RESET_VAL=5
    logic       a_rst, a_ena, a_up_dn, a_load;
    logic [3:0] a_load_bin, a_bin, a_gray;
    logic       a_tc, a_wrap;

    // Instance B: WIDTH=8, RESET_VAL=200
    logic       b_rst, b_ena, b_up_dn, b_load;
    logic [7:0] b_load_bin, b_bin, b_gray;
    logic       b_tc, b_wrap;

    gray_counter #(.WIDTH(4), .RESET_VAL(5)) u_dut_a (
        .clk(clk), .rst(a_rst), .ena(a_ena), .up_dn(a_up_dn), .load(a_load),
        .load_bin(a_load_bin), .bin(a_bin), .gray(a_gray), .tc(a_tc), .wrap(a_wrap)
    );

    gray_counter #(.WIDTH(8), .RESET_VAL(200)) u_dut_b (
        .clk(clk), .rst(b_rst), .ena(b_ena), .up_dn(b_up_dn), .load(b_load),
        .load_bin(b_load_bin), .bin(b_bin), .gray(b_gray), .tc(b_tc), .wrap(b_wrap)
    );

    int checks = 0;
    int errors = 0;

    int ma;       // model value, instance A
    bit mwa;      // model wrap, instance A
    int mb;
    bit mwb;

    logic [3:0] gtab [16];

    // Model of one counting step on an integer in [0, modn).
    function automatic int step_model(input int v, input int modn, input bit up, output bit wrapped);
        wrapped = 1'b0;
        if (up) begin
            if (v == modn - 1) begin
                wrapped = !SAT;
                return SAT ? v : 0;
            end
            return v + 1;
        end
        if (v == 0) begin
            wrapped = !SAT;
            return SAT ? v : modn - 1;
        end
        return v - 1;
    endfunction

    task automatic cyc_a(input logic r, input logic l, input logic [3:0] lb, input logic e, input logic u);
        bit wr;
        a_rst = r; a_load = l; a_load_bin = lb; a_ena = e; a_up_dn = u;
        @(posedge clk);
        #1;
        if (r) begin
            ma = 5; mwa = 1'b0;
        end else if (l) begin
            ma = int'(lb); mwa = 1'b0;
        end else if (e) begin
            ma = step_model(ma, 16, u, wr); mwa = wr;
        end else begin
            mwa = 1'b0;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) cyc_a(1'b1, 1'b0, 4'($urandom), 1'b0, 1'b1);
            else       cyc_a(1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom));
            checks++;
            if (a_bin !== 4'd5) begin errors++; $display("FAIL reset_bin cyc%0d got %0d want 5", i, a_bin); end
            checks++;
            if (a_gray !== 4'b0111) begin errors++; $display("FAIL reset_gray cyc%0d got %b want 0111", i, a_gray); end
            checks++;
            if (a_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap cyc%0d got %b want 0", i, a_wrap); end
            checks++;
            if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_tc cyc%0d got %b want 0", i, a_tc); end
        end
    endtask

    task automatic test_up_sweep;
        logic [3:0] prev;
        cyc_a(1'b0, 1'b1, 4'd0, 1'($urandom), 1'($urandom));
        prev = a_gray;
        for (int i = 0; i < 17; i++) begin
            cyc_a(1'b0, 1'b0, 4'($urandom), 1'b1, 1'b1);
            checks++;
            if (a_bin !== 4'((i + 1) % 16)) begin errors++; $display("FAIL sweep_bin step%0d got %0d want %0d", i, a_bin, (i + 1) % 16); end
            checks++;
            if (a_gray !== gtab[(i + 1) % 16]) begin errors++; $display("FAIL sweep_gray step%0d got %0d want %0d", i, a_gray, gtab[(i + 1) % 16]); end
            checks++;
            if ($countones(a_gray ^ prev) != (SAT && i == 15 ? 0 : 1) && !(SAT && i == 16))
                begin errors++; $display("FAIL sweep_hamming step%0d got %b after %b", i, a_gray, prev); end
            checks++;
            if (a_wrap !== mwa) begin errors++; $display("FAIL sweep_wrap step%0d got %b want %b", i, a_wrap, mwa); end
            checks++;
            if (a_tc !== (ma == 15)) begin errors++; $display("FAIL sweep_tc step%0d got %b want %b", i, a_tc, ma == 15); end
            prev = a_gray;
        end
    endtask

    task automatic test_down_wrap;
        logic [3:0] eb [4];
        logic [3:0] eg [4];
        logic       ew [4];
        if (SAT) begin
            eb = '{4'd1, 4'd0, 4'd0, 4'd0}; eg = '{4'd1, 4'd0, 4'd0, 4'd0}; ew = '{1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            eb = '{4'd1, 4'd0, 4'd15, 4'd14}; eg = '{4'd1, 4'd0, 4'd8, 4'd9}; ew = '{1'b0, 1'b0, 1'b1, 1'b0};
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cyc_a(1'b0, 1'b1, 4'd1, 1'($urandom), 1'b0);
            else        cyc_a(1'b0, 1'b0, 4'($urandom), 1'b1, 1'b0);
            checks++;
            if (a_bin !== eb[i]) begin errors++; $display("FAIL down_bin cyc%0d got %0d want %0d", i, a_bin, eb[i]); end
            checks++;
            if (a_gray !== eg[i]) begin errors++; $display("FAIL down_gray cyc%0d got %0d want %0d", i, a_gray, eg[i]); end
            checks++;
            if (a_wrap !== ew[i]) begin errors++; $display("FAIL down_wrap cyc%0d got %b want %b", i, a_wrap, ew[i]); end
            checks++;
            if (a_tc !== (eb[i] == 4'd0)) begin errors++; $display("FAIL down_tc cyc%0d got %b want %b", i, a_tc, eb[i] == 4'd0); end
        end
    endtask

    task automatic test_priority;
        cyc_a(1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
        checks++;
        if (a_bin !== 4'd5) begin errors++; $display("FAIL prio_rst_bin got %0d want 5", a_bin); end
        cyc_a(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
        checks++;
        if (a_bin !== 4'd9) begin errors++; $display("FAIL prio_load_bin got %0d want 9", a_bin); end
        checks++;
        if (a_gray !== 4'b1101) begin errors++; $display("FAIL prio_load_gray got %b want 1101", a_gray); end
        checks++;
        if (a_wrap !== 1'b0) begin errors++; $display("FAIL prio_load_wrap got %b want 0", a_wrap); end
    endtask

    task automatic test_direction_toggle;
        logic       ud [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] eb [4] = '{4'd8, 4'd7, 4'd6, 4'd7};
        logic [3:0] eg [4] = '{4'd12, 4'd4, 4'd5, 4'd4};
        cyc_a(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 1'b0, 4'($urandom), 1'b1, ud[i]);
            checks++;
            if (a_bin !== eb[i]) begin errors++; $display("FAIL dir_bin cyc%0d got %0d want %0d", i, a_bin, eb[i]); end
            checks++;
            if (a_gray !== eg[i]) begin errors++; $display("FAIL dir_gray cyc%0d got %0d want %0d", i, a_gray, eg[i]); end
            checks++;
            if (a_tc !== 1'b0) begin errors++; $display("FAIL dir_tc cyc%0d got %b want 0", i, a_tc); end
        end
    endtask

    task automatic test_random;
        logic [7:0] prev_gray;
        logic [7:0] lb;
        logic [7:0] exp_gray;
        int         old_m;
        int         exp_flips;
        bit         wr, r, l, e, u;
        int         pick;
        b_rst = 1'b1; b_load = 1'b0; b_ena = 1'b0; b_up_dn = 1'b0; b_load_bin = '0;
        @(posedge clk);
        #1;
        mb = 200; mwb = 1'b0;
        checks++;
        if (b_bin !== 8'd200) begin errors++; $display("FAIL rnd_reset_bin got %0d want 200", b_bin); end
        prev_gray = b_gray;
        for (int n = 0; n < 10000; n++) begin
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 6);
            e = ($urandom_range(0, 99) < 75);
            u = ($urandom_range(0, 99) < 55);
            pick = $urandom_range(0, 4);
            lb = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : (pick == 2) ? 8'd1 : (pick == 3) ? 8'd254 : 8'($urandom);
            b_rst = r; b_load = l; b_ena = e; b_up_dn = u; b_load_bin = lb;
            @(posedge clk);
            #1;
            old_m = mb;
            exp_flips = -1;
            if (r) begin
                mb = 200; mwb = 1'b0;
            end else if (l) begin
                mb = int'(lb); mwb = 1'b0;
            end else if (e) begin
                mb = step_model(mb, 256, u, wr); mwb = wr;
                exp_flips = (mb != old_m) ? 1 : 0;
            end else begin
                mwb = 1'b0;
                exp_flips = 0;
            end
            exp_gray = 8'(mb) ^ (8'(mb) >> 1);
            checks++;
            if (b_bin !== 8'(mb)) begin errors++; $display("FAIL rnd_bin cyc%0d got %0d want %0d", n, b_bin, mb); end
            checks++;
            if (b_gray !== exp_gray) begin errors++; $display("FAIL rnd_gray cyc%0d got %0d want %0d", n, b_gray, exp_gray); end
            checks++;
            if (b_wrap !== mwb) begin errors++; $display("FAIL rnd_wrap cyc%0d got %b want %b", n, b_wrap, mwb); end
            checks++;
            if (b_tc !== ((u && mb == 255) || (!u && mb == 0))) begin
                errors++; $display("FAIL rnd_tc cyc%0d got %b bin %0d up %b", n, b_tc, mb, u);
            end
            if (exp_flips >= 0) begin
                checks++;
                if ($countones(b_gray ^ prev_gray) != exp_flips) begin
                    errors++; $display("FAIL rnd_hamming cyc%0d got %b after %b want %0d flips", n, b_gray, prev_gray, exp_flips);
                end
            end
            prev_gray = b_gray;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) gtab[i] = 4'(i ^ (i >> 1));
        a_rst = 1'b0; a_load = 1'b0; a_ena = 1'b0; a_up_dn = 1'b1; a_load_bin = '0;
        b_rst = 1'b0; b_load = 1'b0; b_ena = 1'b0; b_up_dn = 1'b1; b_load_bin = '0;
        ma = 5; mwa = 1'b0; mb = 200; mwb = 1'b0;
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_priority();
        test_direction_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
